// File: rtl/bus_src_arbiter.sv
// ============================================================================
// Module   : bus_src_arbiter
// Function : Round-robin arbiter for the 8-to-1 bus source mux (hold timeout,
//            per-owner lock, one dead cycle between owners).
// Revision : 1.0
// ============================================================================
`default_nettype none

module bus_src_arbiter #(
  parameter int MAX_HOLD = 4,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       req,
  input  logic [7:0]       lock,
  output logic [7:0]       grant,
  output logic [2:0]       sel,
  output logic             bus_en,
  output logic [CNT_W-1:0] hold_cnt
);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] c_max_hold = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] c_cnt_sat  = {CNT_W{1'b1}};

  state_t           r_state;
  logic [2:0]       r_ptr;
  logic [7:0]       r_grant;
  logic [2:0]       r_sel;
  logic             r_bus_en;
  logic [CNT_W-1:0] r_hold_cnt;

  state_t           w_state_nxt;
  logic [2:0]       w_ptr_nxt;
  logic [7:0]       w_grant_nxt;
  logic [2:0]       w_sel_nxt;
  logic             w_bus_en_nxt;
  logic [CNT_W-1:0] w_hold_nxt;

  logic [7:0]       w_rot;
  logic [2:0]       w_rot_idx;
  logic [2:0]       w_win;
  logic             w_others;
  logic             w_release;

  // Rotate so the pointer position becomes bit 0, pick lowest set bit,
  // then add the pointer back to recover the absolute source index.
  always_comb begin
    w_rot     = 8'h00;
    w_rot_idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      w_rot[i] = req[3'(i) + r_ptr];
    end
    for (int i = 7; i >= 0; i--) begin
      if (w_rot[i]) w_rot_idx = 3'(i);
    end
  end

  assign w_win     = w_rot_idx + r_ptr;
  assign w_others  = |(req & ~r_grant);
  assign w_release = ~req[r_sel] |
                     ((r_hold_cnt >= c_max_hold) & w_others & ~lock[r_sel]);

  always_comb begin
    w_state_nxt  = r_state;
    w_ptr_nxt    = r_ptr;
    w_grant_nxt  = r_grant;
    w_sel_nxt    = r_sel;
    w_bus_en_nxt = r_bus_en;
    w_hold_nxt   = r_hold_cnt;
    case (r_state)
      S_IDLE: begin
        if (|req) begin
          w_state_nxt  = S_GRANT;
          w_grant_nxt  = 8'h01 << w_win;
          w_sel_nxt    = w_win;
          w_bus_en_nxt = 1'b1;
          w_hold_nxt   = {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      S_GRANT: begin
        if (w_release) begin
          w_state_nxt  = S_IDLE;
          w_grant_nxt  = 8'h00;
          w_bus_en_nxt = 1'b0;
          w_hold_nxt   = '0;
          w_ptr_nxt    = r_sel + 3'd1;
        end else if (r_hold_cnt != c_cnt_sat) begin
          w_hold_nxt   = r_hold_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt  = S_IDLE;
        w_grant_nxt  = 8'h00;
        w_bus_en_nxt = 1'b0;
        w_hold_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_ptr      <= 3'd0;
      r_grant    <= 8'h00;
      r_sel      <= 3'd0;
      r_bus_en   <= 1'b0;
      r_hold_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_ptr      <= w_ptr_nxt;
      r_grant    <= w_grant_nxt;
      r_sel      <= w_sel_nxt;
      r_bus_en   <= w_bus_en_nxt;
      r_hold_cnt <= w_hold_nxt;
    end
  end

  assign grant    = r_grant;
  assign sel      = r_sel;
  assign bus_en   = r_bus_en;
  assign hold_cnt = r_hold_cnt;

endmodule

`default_nettype wire

// File: tb/tb_bus_src_arbiter.sv
// ============================================================================
// Module   : tb_bus_src_arbiter
// Function : Directed self-checking bench for bus_src_arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_bus_src_arbiter;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] lock;
  logic [7:0] grant;
  logic [2:0] sel;
  logic       bus_en;
  logic [3:0] hold_cnt;

  int total = 0;
  int bad   = 0;

  bus_src_arbiter #(.MAX_HOLD(4), .CNT_W(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .lock     (lock),
    .grant    (grant),
    .sel      (sel),
    .bus_en   (bus_en),
    .hold_cnt (hold_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one edge, settle, and check the bus_en/grant invariant.
  task automatic step();
    @(posedge clk);
    #1;
    chk("inv_busen", {31'd0, bus_en}, {31'd0, |grant});
  endtask

  // Mux model: in_i carries 16'h1111 * (i+1); bus reads zero when not enabled.
  function automatic logic [15:0] mux_out(input logic [2:0] s, input logic en);
    logic [15:0] v;
    v = 16'h1111 * (16'(s) + 16'd1);
    return en ? v : 16'h0000;
  endfunction

  task automatic expect_grant(input string tag, input logic [7:0] g, input logic [2:0] s,
                              input logic [3:0] h);
    chk({tag, "_grant"}, {24'd0, grant}, {24'd0, g});
    chk({tag, "_sel"},   {29'd0, sel},   {29'd0, s});
    chk({tag, "_hold"},  {28'd0, hold_cnt}, {28'd0, h});
    chk({tag, "_busen"}, {31'd0, bus_en}, {31'd0, (g != 8'h00)});
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 8'h00;
    lock  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    expect_grant("reset", 8'h00, 3'd0, 4'd0);
    rst_n = 1'b1;

    // Idle with no requests
    for (int i = 0; i < 5; i++) begin
      step();
      expect_grant("idle", 8'h00, 3'd0, 4'd0);
    end

    // Single requester on source 2, then drop
    req = 8'h04;
    for (int i = 1; i <= 3; i++) begin
      step();
      expect_grant("src2", 8'h04, 3'd2, 4'(i));
    end
    req = 8'h00;
    step();
    expect_grant("src2_rel", 8'h00, 3'd2, 4'd0);

    // Async reset pulse between edges to restart ptr at 0
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;

    // All requesting: rotate 0..7,0 with 4-cycle holds and one dead cycle each
    req = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      for (int c = 1; c <= 4; c++) begin
        step();
        expect_grant("rr", 8'h01 << (k % 8), 3'(k % 8), 4'(c));
        chk("rr_bus", {16'd0, mux_out(sel, bus_en)}, {16'd0, 16'h1111 * 16'((k % 8) + 1)});
      end
      step();
      chk("rr_dead_grant", {24'd0, grant}, 32'd0);
      chk("rr_dead_busen", {31'd0, bus_en}, 32'd0);
    end
    req = 8'h00;
    step();

    // Serve source 6 so ptr becomes 7, then 7 and 0 compete (wrap-around)
    req = 8'h40;
    step();
    expect_grant("s6", 8'h40, 3'd6, 4'd1);
    req = 8'h00;
    step();
    req = 8'h81;
    for (int c = 1; c <= 4; c++) begin
      step();
      expect_grant("wrap7", 8'h80, 3'd7, 4'(c));
    end
    step();
    expect_grant("wrap_dead", 8'h00, 3'd7, 4'd0);
    step();
    expect_grant("wrap0", 8'h01, 3'd0, 4'd1);
    req = 8'h00;
    step();

    // Source 3 locked against competing requests
    req = 8'h08;
    step();
    expect_grant("lock1", 8'h08, 3'd3, 4'd1);
    req  = 8'h0F;
    lock = 8'h08;
    for (int c = 2; c <= 10; c++) begin
      step();
      expect_grant("lock", 8'h08, 3'd3, 4'(c));
    end
    lock = 8'h00;
    step();
    expect_grant("unlock_rel", 8'h00, 3'd3, 4'd0);
    step();
    expect_grant("unlock_next", 8'h01, 3'd0, 4'd1);

    // Sole requester keeps the bus; hold counter saturates at 15
    req = 8'h01;
    repeat (20) step();
    expect_grant("sat", 8'h01, 3'd0, 4'd15);

    // Move ptr to 5, grant source 0, then reset mid-grant
    req = 8'h00;
    step();
    req = 8'h10;
    step();
    expect_grant("s4", 8'h10, 3'd4, 4'd1);
    req = 8'h00;
    step();
    req = 8'h01;
    step();
    expect_grant("pre_rst", 8'h01, 3'd0, 4'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_grant", {24'd0, grant}, 32'd0);
    chk("async_busen", {31'd0, bus_en}, 32'd0);
    req   = 8'h30;
    rst_n = 1'b1;
    step();
    expect_grant("post_rst", 8'h10, 3'd4, 4'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
